// File: rtl/fast_inv_sqrt_nr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fast_inv_sqrt_nr - iterative fixed-point 1/sqrt(x): magic seed + NR_ITERS
// Newton-Raphson steps, one transaction in flight.   Rev 1.0
// ---------------------------------------------------------------------------
module fast_inv_sqrt_nr #(
   parameter int          INT_WIDTH   = 4,
   parameter int          FRACT_WIDTH = 6,
   parameter int          NR_ITERS    = 1,
   parameter int          GUARD_BITS  = 4,
   parameter logic [31:0] MAGIC       = 32'h5F3759DF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [INT_WIDTH+FRACT_WIDTH-1:0] data_in,
   input  logic                             valid_in,
   output logic                             ready_in,
   output logic [INT_WIDTH+FRACT_WIDTH-1:0] data_out,
   output logic                             valid_out,
   input  logic                             ready_out,
   output logic                             sat_out
);

   localparam int W  = INT_WIDTH + FRACT_WIDTH;
   localparam int FB = FRACT_WIDTH + GUARD_BITS;
   // y can reach 2^(FRACT_WIDTH/2) for the smallest x; two spare bits absorb NR overshoot.
   localparam int YI = FRACT_WIDTH / 2 + 3;
   localparam int YW = YI + FB;
   localparam int XW = W + GUARD_BITS;
   localparam int SW = 2 * YI + FB;
   localparam int TW = INT_WIDTH + 2 * YI + FB;
   localparam int HW = FB + 1;
   localparam int RW = YW + 1;

   localparam logic [TW-1:0] C_THREE_HALF = TW'(3) << (FB - 1);
   localparam logic [RW-1:0] C_HALF       = (RW'(1) << GUARD_BITS) >> 1;
   localparam logic [63:0]   C_MAX        = (64'd1 << W) - 64'd1;
   localparam logic [1:0]    C_LAST_ITER  = 2'(NR_ITERS - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CONV,
      ST_SEED,
      ST_NR_SQ,
      ST_NR_MUL,
      ST_NR_UPD,
      ST_PACK,
      ST_SAT,
      ST_OUT
   } state_t;

   state_t         state_q, state_d;
   logic           started_q;
   logic [1:0]     iter_q;
   logic [W-1:0]   x_q;
   logic           zero_q;
   logic [31:0]    xf_q;
   logic [XW-1:0]  xh_q;
   logic [YW-1:0]  y_q;
   logic [SW-1:0]  sq_q;
   logic [TW-1:0]  t_q;
   logic [RW-1:0]  rnd_q;
   logic [W-1:0]   data_q;
   logic           sat_q;

   logic [7:0]        lod_pos;
   logic [31:0]       xf_d;
   logic [XW-1:0]     xh_d;
   logic [31:0]       yf;
   int                seed_sh;
   logic [63:0]       seed_wide;
   logic [YW-1:0]     y0_d;
   logic [2*YW-1:0]   sq_full;
   logic [SW-1:0]     sq_d;
   logic [XW+SW-1:0]  t_full;
   logic [TW-1:0]     t_d;
   logic [HW-1:0]     h;
   logic [YW+HW-1:0]  yh_full;
   logic [RW-1:0]     ynew;
   logic [YW-1:0]     y_upd_d;
   logic [RW-1:0]     rnd_d;
   logic              sat_d;
   logic [W-1:0]      pack_d;

   assign ready_in  = (state_q == ST_IDLE) && started_q;
   assign valid_out = (state_q == ST_OUT);
   assign data_out  = data_q;
   assign sat_out   = sat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         started_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (valid_in && ready_in) state_d = ST_CONV;
         ST_CONV:   state_d = ST_SEED;
         ST_SEED:   state_d = ST_NR_SQ;
         ST_NR_SQ:  state_d = ST_NR_MUL;
         ST_NR_MUL: state_d = ST_NR_UPD;
         ST_NR_UPD: state_d = (iter_q == C_LAST_ITER) ? ST_PACK : ST_NR_SQ;
         ST_PACK:   state_d = ST_SAT;
         ST_SAT:    state_d = ST_OUT;
         ST_OUT:    if (ready_out) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Fixed-point x to IEEE single: leading one sets the exponent, bits below it the mantissa.
   always_comb begin
      lod_pos = 8'd0;
      for (int i = 0; i < W; i++) begin
         if (x_q[i]) lod_pos = 8'(i);
      end
   end

   assign xf_d = {1'b0, lod_pos + 8'd127 - 8'(FRACT_WIDTH),
                  23'(({x_q, 23'd0} >> lod_pos))};
   assign xh_d = (XW'(x_q) << GUARD_BITS) >> 1;

   // Seed back to fixed point: significand scaled by 2^(e-127+FB-23).
   always_comb begin
      yf      = MAGIC - (xf_q >> 1);
      seed_sh = int'(yf[30:23]) - (150 - FB);
      if (seed_sh >= 0) seed_wide = {40'd0, 1'b1, yf[22:0]} << seed_sh;
      else              seed_wide = {40'd0, 1'b1, yf[22:0]} >> (-seed_sh);
      y0_d = (yf[31] || (|seed_wide[63:YW])) ? '1 : seed_wide[YW-1:0];
   end

   assign sq_full = {{YW{1'b0}}, y_q} * {{YW{1'b0}}, y_q};
   assign sq_d    = SW'(sq_full >> FB);
   assign t_full  = {{SW{1'b0}}, xh_q} * {{XW{1'b0}}, sq_q};
   assign t_d     = TW'(t_full >> FB);

   // A wild seed could push xh*y^2 past 1.5; clamp the correction factor at zero.
   always_comb begin
      h       = (t_q >= C_THREE_HALF) ? '0 : HW'(C_THREE_HALF - t_q);
      yh_full = {{HW{1'b0}}, y_q} * {{YW{1'b0}}, h};
      ynew    = RW'(yh_full >> FB);
      y_upd_d = ynew[YW] ? '1 : ynew[YW-1:0];
   end

   assign rnd_d  = (RW'(y_q) + C_HALF) >> GUARD_BITS;
   assign sat_d  = zero_q || (64'(rnd_q) > C_MAX);
   assign pack_d = sat_d ? '1 : W'(rnd_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_q <= '0;
         x_q    <= '0;
         zero_q <= 1'b0;
         xf_q   <= '0;
         xh_q   <= '0;
         y_q    <= '0;
         sq_q   <= '0;
         t_q    <= '0;
         rnd_q  <= '0;
         data_q <= '0;
         sat_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_in && ready_in) begin
                  x_q    <= data_in;
                  zero_q <= (data_in == '0);
               end
            end
            ST_CONV: begin
               xf_q <= xf_d;
               xh_q <= xh_d;
            end
            ST_SEED: begin
               y_q    <= y0_d;
               iter_q <= '0;
            end
            ST_NR_SQ:  sq_q <= sq_d;
            ST_NR_MUL: t_q  <= t_d;
            ST_NR_UPD: begin
               y_q    <= y_upd_d;
               iter_q <= iter_q + 2'd1;
            end
            ST_PACK:   rnd_q <= rnd_d;
            ST_SAT: begin
               data_q <= pack_d;
               sat_q  <= sat_d;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fast_inv_sqrt_nr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fast_inv_sqrt_nr - directed bench: default, NR_ITERS=3, FRACT_WIDTH=12.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fast_inv_sqrt_nr;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [9:0]  din_a = '0, dout_a;
   logic        vin_a = 1'b0, rdy_a, vout_a, rout_a = 1'b0, sat_a;
   logic [9:0]  din_b = '0, dout_b;
   logic        vin_b = 1'b0, rdy_b, vout_b, rout_b = 1'b0, sat_b;
   logic [15:0] din_c = '0, dout_c;
   logic        vin_c = 1'b0, rdy_c, vout_c, rout_c = 1'b0, sat_c;

   int n_vec = 0;
   int n_err = 0;

   fast_inv_sqrt_nr u_dut_a (
      .clk(clk), .rst(rst), .data_in(din_a), .valid_in(vin_a), .ready_in(rdy_a),
      .data_out(dout_a), .valid_out(vout_a), .ready_out(rout_a), .sat_out(sat_a));

   fast_inv_sqrt_nr #(.NR_ITERS(3)) u_dut_b (
      .clk(clk), .rst(rst), .data_in(din_b), .valid_in(vin_b), .ready_in(rdy_b),
      .data_out(dout_b), .valid_out(vout_b), .ready_out(rout_b), .sat_out(sat_b));

   fast_inv_sqrt_nr #(.FRACT_WIDTH(12)) u_dut_c (
      .clk(clk), .rst(rst), .data_in(din_c), .valid_in(vin_c), .ready_in(rdy_c),
      .data_out(dout_c), .valid_out(vout_c), .ready_out(rout_c), .sat_out(sat_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
      n_vec++;
      assert (((obs >= 32'(lo)) && (obs <= 32'(hi))) === 1'b1) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   function automatic logic get_vout(input int sel);
      case (sel)
         0:       return vout_a;
         1:       return vout_b;
         default: return vout_c;
      endcase
   endfunction

   function automatic logic get_sat(input int sel);
      case (sel)
         0:       return sat_a;
         1:       return sat_b;
         default: return sat_c;
      endcase
   endfunction

   function automatic logic [15:0] get_dout(input int sel);
      case (sel)
         0:       return {6'd0, dout_a};
         1:       return {6'd0, dout_b};
         default: return dout_c;
      endcase
   endfunction

   task automatic drive(input int sel, input logic [15:0] x, input logic v);
      case (sel)
         0:       begin din_a = x[9:0]; vin_a = v; end
         1:       begin din_b = x[9:0]; vin_b = v; end
         default: begin din_c = x;      vin_c = v; end
      endcase
   endtask

   task automatic set_rout(input int sel, input logic v);
      case (sel)
         0:       rout_a = v;
         1:       rout_b = v;
         default: rout_c = v;
      endcase
   endtask

   // Accept at edge k, then require valid_out low after edges k..k+lat-1 and high after k+lat.
   task automatic xact(input int sel, input logic [15:0] x, input int lat,
                       output logic [15:0] y, output logic s, output logic lat_ok);
      logic early;
      early = 1'b0;
      @(negedge clk);
      drive(sel, x, 1'b1);
      @(posedge clk);
      #1 drive(sel, x, 1'b0);
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         early = early | get_vout(sel);
      end
      @(negedge clk);
      lat_ok = !early && (get_vout(sel) === 1'b1);
      y = get_dout(sel);
      s = get_sat(sel);
   endtask

   task automatic consume(input int sel);
      @(negedge clk);
      set_rout(sel, 1'b1);
      @(posedge clk);
      #1 set_rout(sel, 1'b0);
   endtask

   initial begin
      logic [15:0] y;
      logic        s, ok, stable, lat_all, sat_any;
      logic [9:0]  held;
      int          e;
      real         r;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready_in", rdy_a, 0);
      chk("rst_valid_out", vout_a, 0);
      chk("rst_data_out", dout_a, 0);
      chk("rst_sat_out", sat_a, 0);
      rst = 1'b0;
      #1 chk("ready_before_edge", rdy_a, 0);
      @(posedge clk);
      #1 chk("ready_after_edge", rdy_a, 1);

      // x = 0.5 -> 64*sqrt(2) = 90.5
      xact(0, 16'd32, 7, y, s, ok);
      chk("x0p5_latency", ok, 1);
      chk_rng("x0p5_data", y, 89, 91);
      chk("x0p5_sat", s, 0);
      consume(0);
      chk("x0p5_consume_valid", vout_a, 0);
      chk("x0p5_consume_ready", rdy_a, 1);

      // x = 1.5 -> 52.26, x = 13.4375 -> 17.46
      xact(0, 16'd96, 7, y, s, ok);
      chk("x1p5_latency", ok, 1);
      chk_rng("x1p5_data", y, 51, 53);
      consume(0);
      xact(0, 16'd860, 7, y, s, ok);
      chk("x13p4_latency", ok, 1);
      chk_rng("x13p4_data", y, 16, 18);
      chk("x13p4_sat", s, 0);
      consume(0);

      xact(0, 16'd0, 7, y, s, ok);
      chk("zero_latency", ok, 1);
      chk("zero_data", y, 32'h3FF);
      chk("zero_sat", s, 1);
      consume(0);

      // Q4.12, x = 2^-12 -> y = 64, beyond the largest code
      xact(2, 16'd1, 7, y, s, ok);
      chk("f12_lsb_latency", ok, 1);
      chk("f12_lsb_data", y, 32'hFFFF);
      chk("f12_lsb_sat", s, 1);
      consume(2);

      // x = 2.0 -> 45.25; hold output 20 cycles while new input is offered
      xact(0, 16'd128, 7, y, s, ok);
      chk("x2_latency", ok, 1);
      chk_rng("x2_data", y, 44, 46);
      held = dout_a;
      drive(0, 16'h155, 1'b1);
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         stable = stable && (dout_a === held) && (vout_a === 1'b1)
                         && (rdy_a === 1'b0) && (sat_a === 1'b0);
      end
      chk("hold_stable", stable, 1);
      consume(0);
      chk("hold_consume_valid", vout_a, 0);
      chk("hold_consume_ready", rdy_a, 1);
      drive(0, 16'd0, 1'b0);

      xact(1, 16'd32, 13, y, s, ok);
      chk("nr3_latency", ok, 1);
      chk_rng("nr3_x0p5_data", y, 90, 92);
      consume(1);

      lat_all = 1'b1;
      sat_any = 1'b0;
      for (int code = 1; code < 1024; code++) begin
         xact(1, 16'(code), 13, y, s, ok);
         lat_all = lat_all && ok;
         sat_any = sat_any || (s !== 1'b0);
         r = 512.0 / $sqrt(real'(code));
         e = $rtoi(r + 0.5);
         chk_rng($sformatf("nr3_sweep_x%0d", code), y, e - 1, e + 1);
         consume(1);
      end
      chk("nr3_sweep_latency", lat_all, 1);
      chk("nr3_sweep_sat", sat_any, 0);

      // Reset three edges after an accept aborts the computation
      @(negedge clk);
      drive(0, 16'd96, 1'b1);
      @(posedge clk);
      #1 drive(0, 16'd96, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_valid", vout_a, 0);
      chk("abort_ready", rdy_a, 0);
      chk("abort_data", dout_a, 0);
      chk("abort_sat", sat_a, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 chk("abort_ready_release", rdy_a, 1);
      xact(0, 16'd860, 7, y, s, ok);
      chk("after_abort_latency", ok, 1);
      chk_rng("after_abort_data", y, 16, 18);
      consume(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
